// File: rtl/mult_pkg.sv
// mult_pkg: state encodings and width helper shared by the chunked multiplier controller.
package mult_pkg;
    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_CALC = 3'b001;
    localparam logic [2:0] ST_DONE = 3'b010;
    localparam logic [2:0] ST_ERR  = 3'b011;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } state_t;

    // Never returns less than 1 so single-value fields still get a bit.
    function automatic int clog2(input int v);
        int r = 1;
        for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/mult_control_param_if.sv
// mult_control_param_if: controller <-> datapath signals; count exists only with MULT_CTRL_CNT_CHECK_EN.
interface mult_control_param_if
    import mult_pkg::*;
#(
    parameter int NCHUNK  = 2,
    parameter int CHUNK_W = 4
);
    localparam int DATA_W = NCHUNK * CHUNK_W;
    localparam int SEL_W  = clog2(NCHUNK);
    localparam int SH_W   = clog2(2 * DATA_W);
    localparam int STEP_W = clog2(NCHUNK * NCHUNK);

    logic              start;
    logic [SEL_W-1:0]  a_sel;
    logic [SEL_W-1:0]  b_sel;
    logic [SH_W-1:0]   shift_bits;
    logic              clk_ena;
    logic              sclr_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        state_out;
    logic [STEP_W-1:0] step_out;
`ifdef MULT_CTRL_CNT_CHECK_EN
    logic [STEP_W-1:0] count;

    modport master (input start, count,
                    output a_sel, b_sel, shift_bits, clk_ena, sclr_n, busy, done, err, state_out, step_out);
    modport slave  (output start, count,
                    input a_sel, b_sel, shift_bits, clk_ena, sclr_n, busy, done, err, state_out, step_out);
`else
    modport master (input start,
                    output a_sel, b_sel, shift_bits, clk_ena, sclr_n, busy, done, err, state_out, step_out);
    modport slave  (output start,
                    input a_sel, b_sel, shift_bits, clk_ena, sclr_n, busy, done, err, state_out, step_out);
`endif
endinterface

// File: rtl/mult_step_counter.sv
// mult_step_counter: partial-product step register with clear/increment, last flag and chunk-select decode.
module mult_step_counter #(
    parameter int NCHUNK = 2,
    parameter int STEP_W = 2,
    parameter int SEL_W  = 1
) (
    input  logic              clk,
    input  logic              reset_a,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [STEP_W-1:0] o_step,
    output logic              o_last,
    output logic [SEL_W-1:0]  o_a_sel,
    output logic [SEL_W-1:0]  o_b_sel
);
    localparam int STEPS = NCHUNK * NCHUNK;

    logic [STEP_W-1:0] r_step;

    always_ff @(posedge clk) begin
        if (reset_a || i_clr) r_step <= '0;
        else if (i_inc) r_step <= r_step + 1'b1;
    end

    // A walks fastest, so each B chunk sees every A chunk in turn.
    assign o_step  = r_step;
    assign o_last  = r_step == STEP_W'(STEPS - 1);
    assign o_a_sel = SEL_W'(32'(r_step) % NCHUNK);
    assign o_b_sel = SEL_W'(32'(r_step) / NCHUNK);
endmodule

// File: rtl/mult_control_param.sv
// mult_control_param: sequencing FSM for an NCHUNK x NCHUNK chunked shift-and-add multiplier.
// Optional MULT_CTRL_CNT_CHECK_EN cross-checks the datapath step count against the internal step.
module mult_control_param
    import mult_pkg::*;
#(
    parameter int NCHUNK  = 2,
    parameter int CHUNK_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_a,
    mult_control_param_if.master bus
);
    localparam int STEPS  = NCHUNK * NCHUNK;
    localparam int SEL_W  = clog2(NCHUNK);
    localparam int SH_W   = clog2(2 * NCHUNK * CHUNK_W);
    localparam int STEP_W = clog2(STEPS);

    state_t            r_state;
    state_t            w_next;
    logic              w_inc;
    logic              w_last;
    logic              w_bad_cnt;
    logic [STEP_W-1:0] w_step;
    logic [SEL_W-1:0]  w_a_sel;
    logic [SEL_W-1:0]  w_b_sel;

    mult_step_counter #(
        .NCHUNK (NCHUNK),
        .STEP_W (STEP_W),
        .SEL_W  (SEL_W)
    ) u_step (
        .clk     (clk),
        .reset_a (reset_a),
        .i_clr   (!w_inc),
        .i_inc   (w_inc),
        .o_step  (w_step),
        .o_last  (w_last),
        .o_a_sel (w_a_sel),
        .o_b_sel (w_b_sel)
    );

`ifdef MULT_CTRL_CNT_CHECK_EN
    assign w_bad_cnt = bus.count != w_step;
`else
    assign w_bad_cnt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_a) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Step only advances while staying in CALC; every other transition zeroes it.
    assign w_inc = (r_state == CALC) && (w_next == CALC);

    always_comb begin
        w_next      = IDLE;
        bus.clk_ena = 1'b0;
        bus.sclr_n  = 1'b1;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.err     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next      = bus.start ? CALC : IDLE;
                bus.clk_ena = bus.start;
                bus.sclr_n  = !bus.start;
            end
            CALC: begin
                bus.busy    = 1'b1;
                w_next      = (bus.start || w_bad_cnt) ? ERR : (w_last ? DONE : CALC);
                bus.clk_ena = !(bus.start || w_bad_cnt);
            end
            DONE: begin
                bus.done    = 1'b1;
                w_next      = bus.start ? CALC : IDLE;
                bus.clk_ena = bus.start;
                bus.sclr_n  = !bus.start;
            end
            ERR: begin
                bus.err     = 1'b1;
                w_next      = bus.start ? CALC : ERR;
                bus.clk_ena = bus.start;
                bus.sclr_n  = !bus.start;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.a_sel      = w_a_sel;
    assign bus.b_sel      = w_b_sel;
    assign bus.shift_bits = SH_W'((32'(w_a_sel) + 32'(w_b_sel)) * CHUNK_W);
    assign bus.state_out  = r_state;
    assign bus.step_out   = w_step;
endmodule

// File: tb/tb_mult_control_param.sv
// tb_mult_control_param: directed checks of the 2x2 and 4x4 chunk controllers.
module tb_mult_control_param;
    logic clk = 1'b0;
    logic reset_a = 1'b1;
    int total = 0;
    int bad = 0;

    int ea[4]  = '{0, 1, 0, 1};
    int eb[4]  = '{0, 0, 1, 1};
    int esh[4] = '{0, 4, 4, 8};

    always #5 clk = ~clk;

    mult_control_param_if #(.NCHUNK(2), .CHUNK_W(4)) bus();
    mult_control_param_if #(.NCHUNK(4), .CHUNK_W(8)) bus4();

    mult_control_param #(.NCHUNK(2), .CHUNK_W(4)) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    mult_control_param #(.NCHUNK(4), .CHUNK_W(8)) dut4 (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus4)
    );

`ifdef MULT_CTRL_CNT_CHECK_EN
    logic force_cnt = 1'b0;
    always_comb bus.count = force_cnt ? 2'd2 : bus.step_out;
    always_comb bus4.count = bus4.step_out;
`endif

    // Observation word: state, clk_ena, sclr_n, busy, done, err, a_sel, b_sel, shift_bits, step
    function automatic logic [15:0] snap();
        return {bus.state_out, bus.clk_ena, bus.sclr_n, bus.busy, bus.done, bus.err,
                bus.a_sel, bus.b_sel, bus.shift_bits, bus.step_out};
    endfunction

    function automatic logic [15:0] pk(int st, int ce, int sc, int bz, int dn, int er,
                                       int a, int b, int sh, int stp);
        return {3'(st), 1'(ce), 1'(sc), 1'(bz), 1'(dn), 1'(er), 1'(a), 1'(b), 4'(sh), 2'(stp)};
    endfunction

    task automatic cyc(input logic s);
        @(posedge clk);
        #1;
        bus.start = s;
        #2;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        cyc(0);
        cyc(0);
        reset_a = 1'b0;
        #1;
        e = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL reset: got %h want %h", snap(), e); end
        total++;
        if ({bus4.state_out, bus4.step_out, bus4.clk_ena, bus4.sclr_n} !== 9'b000_0000_01) begin
            bad++;
            $display("FAIL reset_wide: got %b want 000000001", {bus4.state_out, bus4.step_out, bus4.clk_ena, bus4.sclr_n});
        end
    endtask

    task automatic test_single();
        logic [15:0] e;
        cyc(1);
        e = pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL single_start: got %h want %h", snap(), e); end
        for (int k = 0; k < 4; k++) begin
            cyc(0);
            e = pk(1, 1, 1, 1, 0, 0, ea[k], eb[k], esh[k], k);
            total++;
            if (snap() !== e) begin bad++; $display("FAIL single_calc%0d: got %h want %h", k, snap(), e); end
        end
        cyc(0);
        e = pk(2, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL single_done: got %h want %h", snap(), e); end
        cyc(0);
        e = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL single_idle: got %h want %h", snap(), e); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        cyc(1);
        for (int k = 0; k < 4; k++) cyc(0);
        cyc(1);
        e = pk(2, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL b2b_restart: got %h want %h", snap(), e); end
        for (int k = 0; k < 4; k++) begin
            cyc(0);
            e = pk(1, 1, 1, 1, 0, 0, ea[k], eb[k], esh[k], k);
            total++;
            if (snap() !== e) begin bad++; $display("FAIL b2b_calc%0d: got %h want %h", k, snap(), e); end
        end
        cyc(0);
        e = pk(2, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL b2b_done2: got %h want %h", snap(), e); end
        cyc(0);
    endtask

    task automatic test_error();
        logic [15:0] e;
        cyc(1);
        cyc(1);
        e = pk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL err_violation: got %h want %h", snap(), e); end
        for (int k = 0; k < 11; k++) begin
            cyc(0);
            e = pk(3, 0, 1, 0, 0, 1, 0, 0, 0, 0);
            total++;
            if (snap() !== e) begin bad++; $display("FAIL err_hold%0d: got %h want %h", k, snap(), e); end
        end
        cyc(1);
        e = pk(3, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL err_restart: got %h want %h", snap(), e); end
        for (int k = 0; k < 4; k++) begin
            cyc(0);
            e = pk(1, 1, 1, 1, 0, 0, ea[k], eb[k], esh[k], k);
            total++;
            if (snap() !== e) begin bad++; $display("FAIL err_calc%0d: got %h want %h", k, snap(), e); end
        end
        cyc(0);
        e = pk(2, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL err_done: got %h want %h", snap(), e); end
        cyc(0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        cyc(1);
        cyc(0);
        cyc(0);
        cyc(0);
        e = pk(1, 1, 1, 1, 0, 0, 0, 1, 4, 2);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL rmid_step2: got %h want %h", snap(), e); end
        reset_a = 1'b1;
        cyc(0);
        reset_a = 1'b0;
        e = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL rmid_idle: got %h want %h", snap(), e); end
        for (int k = 0; k < 6; k++) begin
            cyc(0);
            total++;
            if ({bus.done, bus.state_out} !== 4'b0000) begin
                bad++;
                $display("FAIL rmid_nodone%0d: got %b want 0000", k, {bus.done, bus.state_out});
            end
        end
    endtask

    task automatic test_wide();
        @(posedge clk);
        #1;
        bus4.start = 1'b1;
        #2;
        total++;
        if ({bus4.sclr_n, bus4.clk_ena} !== 2'b01) begin
            bad++;
            $display("FAIL wide_start: got %b want 01", {bus4.sclr_n, bus4.clk_ena});
        end
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            bus4.start = 1'b0;
            #2;
            total++;
            if ({bus4.busy, bus4.done, bus4.step_out} !== {2'b10, 4'(c - 1)}) begin
                bad++;
                $display("FAIL wide_calc%0d: got %b want %b", c, {bus4.busy, bus4.done, bus4.step_out}, {2'b10, 4'(c - 1)});
            end
            if (c == 14) begin
                total++;
                if ({bus4.a_sel, bus4.b_sel, bus4.shift_bits} !== {2'd1, 2'd3, 6'd32}) begin
                    bad++;
                    $display("FAIL wide_step13: got %h want %h", {bus4.a_sel, bus4.b_sel, bus4.shift_bits}, {2'd1, 2'd3, 6'd32});
                end
            end
        end
        @(posedge clk);
        #3;
        total++;
        if ({bus4.done, bus4.state_out} !== 4'b1010) begin
            bad++;
            $display("FAIL wide_done: got %b want 1010", {bus4.done, bus4.state_out});
        end
        @(posedge clk);
    endtask

`ifdef MULT_CTRL_CNT_CHECK_EN
    task automatic test_cnt_check();
        logic [15:0] e;
        cyc(1);
        cyc(0);
        @(posedge clk);
        #1;
        force_cnt = 1'b1;
        #2;
        e = pk(1, 0, 1, 1, 0, 0, 1, 0, 4, 1);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL cnt_mismatch: got %h want %h", snap(), e); end
        @(posedge clk);
        #1;
        force_cnt = 1'b0;
        #2;
        e = pk(3, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (snap() !== e) begin bad++; $display("FAIL cnt_err: got %h want %h", snap(), e); end
        for (int k = 0; k < 5; k++) begin
            cyc(0);
            total++;
            if ({bus.done, bus.err} !== 2'b01) begin
                bad++;
                $display("FAIL cnt_nodone%0d: got %b want 01", k, {bus.done, bus.err});
            end
        end
        cyc(1);
        for (int k = 0; k < 6; k++) cyc(0);
    endtask
`endif

    initial begin
        bus.start  = 1'b0;
        bus4.start = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_wide();
`ifdef MULT_CTRL_CNT_CHECK_EN
        test_cnt_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
